// File: rtl/game_pkg.sv
// Shared definitions for the ship life controller: state encodings and
// the default number of lives loaded at the start of a game.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_HIT  = 2'd2,
        ST_OVER = 2'd3
    } state_t;

    localparam int LIVES_INIT_DEF = 3;

endpackage

// File: rtl/life_invuln_timer.sv
// Invulnerability window counter. Loaded with INVULN_FRAMES-1 on a hit,
// counts frames down to zero and holds there. The blink bit is taken
// straight from the counter so the ship flashes while the window runs.
module life_invuln_timer #(
    parameter int INVULN_FRAMES = 120,
    parameter int BLINK_SHIFT   = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o,
    output logic blink_o
);

    // Wide enough for the load value and for the blink bit position.
    localparam int CNT_W = ($clog2(INVULN_FRAMES + 1) > (BLINK_SHIFT + 1))
                         ? $clog2(INVULN_FRAMES + 1) : (BLINK_SHIFT + 1);

    logic [CNT_W-1:0] cnt_q;

    // Load has priority over decrement; the counter parks at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= CNT_W'(INVULN_FRAMES - 1);
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign zero_o  = (cnt_q == '0);
    assign blink_o = cnt_q[BLINK_SHIFT];

endmodule

// File: rtl/ship_life_ctrl.sv
// Ship life controller: tracks lives, the post-hit invulnerability window,
// game over and a saturating survival score for one game at a time.
// All state changes are qualified by the pixel enable.
module ship_life_ctrl
    import game_pkg::*;
#(
    parameter int LIVES_INIT    = LIVES_INIT_DEF,
    parameter int LIVES_W       = 2,
    parameter int INVULN_FRAMES = 120,
    parameter int BLINK_SHIFT   = 3,
    parameter int SCORE_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pixpulse,
    input  logic               frame_tick,
    input  logic               hit,
    input  logic               start,
    output logic [LIVES_W-1:0] lives,
    output logic               playing,
    output logic               invuln,
    output logic               ship_visible,
    output logic               respawn,
    output logic               game_over,
    output logic [SCORE_W-1:0] score
);

    state_t             state_q;
    logic [LIVES_W-1:0] lives_q;
    logic [SCORE_W-1:0] score_q;
    logic               respawn_q;
    logic               start_q;

    logic               tick;
    logic               start_rise;
    logic [SCORE_W-1:0] score_inc;
    logic               tmr_load;
    logic               tmr_dec;
    logic               tmr_zero;
    logic               tmr_blink;

    assign tick       = pixpulse & frame_tick;
    assign start_rise = pixpulse & start & ~start_q;
    assign score_inc  = (score_q == '1) ? score_q : (score_q + SCORE_W'(1));

    // Window opens on a non-fatal hit in PLAY and runs down on frame ticks in HIT.
    assign tmr_load = (state_q == ST_PLAY) && tick && hit && (lives_q != LIVES_W'(1));
    assign tmr_dec  = (state_q == ST_HIT) && tick;

    life_invuln_timer #(
        .INVULN_FRAMES (INVULN_FRAMES),
        .BLINK_SHIFT   (BLINK_SHIFT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load_i  (tmr_load),
        .dec_i   (tmr_dec),
        .zero_o  (tmr_zero),
        .blink_o (tmr_blink)
    );

    // Game FSM together with lives, score, respawn pulse and start edge detector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            lives_q   <= '0;
            score_q   <= '0;
            respawn_q <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            respawn_q <= 1'b0;
            if (pixpulse) begin
                start_q <= start;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start_rise) begin
                        state_q   <= ST_PLAY;
                        lives_q   <= LIVES_W'(LIVES_INIT);
                        score_q   <= '0;
                        respawn_q <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (tick) begin
                        if (hit) begin
                            if (lives_q == LIVES_W'(1)) begin
                                state_q <= ST_OVER;
                                lives_q <= '0;
                            end else begin
                                state_q   <= ST_HIT;
                                lives_q   <= lives_q - LIVES_W'(1);
                                respawn_q <= 1'b1;
                            end
                        end else begin
                            score_q <= score_inc;
                        end
                    end
                end
                ST_HIT: begin
                    // Hits are ignored here; the window only closes on a hit-free tick.
                    if (tick) begin
                        score_q <= score_inc;
                        if (tmr_zero && !hit) begin
                            state_q <= ST_PLAY;
                        end
                    end
                end
                default: begin
                    // Game over: score held for the HUD until the next game starts.
                    lives_q <= '0;
                    if (start_rise) begin
                        state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Visibility: solid while playing, blinking during the window, hidden otherwise.
    always_comb begin
        ship_visible = 1'b0;
        case (state_q)
            ST_PLAY: ship_visible = 1'b1;
            ST_HIT:  ship_visible = ~tmr_blink;
            default: ship_visible = 1'b0;
        endcase
    end

    assign lives     = lives_q;
    assign score     = score_q;
    assign respawn   = respawn_q;
    assign playing   = (state_q == ST_PLAY) || (state_q == ST_HIT);
    assign invuln    = (state_q == ST_HIT);
    assign game_over = (state_q == ST_OVER);

endmodule
